// File: rtl/bcd_display_pkg.sv
// Shared types and constants for the multiplexed three-digit BCD display scanner.
package bcd_display_pkg;

   localparam int unsigned DIGIT_W = 4;
   localparam int unsigned SEG_W   = 7;
   localparam int unsigned AN_W    = 3;

   typedef enum logic [1:0] {
      S_ONES = 2'd0,
      S_TENS = 2'd1,
      S_HUND = 2'd2
   } scan_state_e;

   typedef struct packed {
      logic [DIGIT_W-1:0] hundreds;
      logic [DIGIT_W-1:0] tens;
      logic [DIGIT_W-1:0] ones;
   } bcd_digits_t;

   // Active-high segment patterns, bit order {g,f,e,d,c,b,a}
   localparam logic [SEG_W-1:0] SEG_0    = 7'h3F;
   localparam logic [SEG_W-1:0] SEG_1    = 7'h06;
   localparam logic [SEG_W-1:0] SEG_2    = 7'h5B;
   localparam logic [SEG_W-1:0] SEG_3    = 7'h4F;
   localparam logic [SEG_W-1:0] SEG_4    = 7'h66;
   localparam logic [SEG_W-1:0] SEG_5    = 7'h6D;
   localparam logic [SEG_W-1:0] SEG_6    = 7'h7D;
   localparam logic [SEG_W-1:0] SEG_7    = 7'h07;
   localparam logic [SEG_W-1:0] SEG_8    = 7'h7F;
   localparam logic [SEG_W-1:0] SEG_9    = 7'h6F;
   localparam logic [SEG_W-1:0] SEG_DASH = 7'h40;
   localparam logic [SEG_W-1:0] SEG_OFF  = 7'h00;

endpackage

// File: rtl/bcd_display_scan_if.sv
// Digit load bus and display drive signals of the BCD display scanner.
interface bcd_display_scan_if;
   import bcd_display_pkg::*;

   logic               load;
   logic [DIGIT_W-1:0] hundreds;
   logic [DIGIT_W-1:0] tens;
   logic [DIGIT_W-1:0] ones;
   logic               blank_lz;
   logic [SEG_W-1:0]   seg;
   logic [AN_W-1:0]    an;
   logic               frame_start;

   modport master (
      output load, hundreds, tens, ones, blank_lz,
      input  seg, an, frame_start
   );

   modport slave (
      input  load, hundreds, tens, ones, blank_lz,
      output seg, an, frame_start
   );

endinterface

// File: rtl/seg7_decode.sv
// BCD digit to active-high seven-segment pattern; non-decimal codes show a dash.
module seg7_decode
   import bcd_display_pkg::*;
(
   input  logic [DIGIT_W-1:0] digit,
   output logic [SEG_W-1:0]   seg_c
);

   always_comb begin
      seg_c = SEG_DASH;
      case (digit)
         4'd0:    seg_c = SEG_0;
         4'd1:    seg_c = SEG_1;
         4'd2:    seg_c = SEG_2;
         4'd3:    seg_c = SEG_3;
         4'd4:    seg_c = SEG_4;
         4'd5:    seg_c = SEG_5;
         4'd6:    seg_c = SEG_6;
         4'd7:    seg_c = SEG_7;
         4'd8:    seg_c = SEG_8;
         4'd9:    seg_c = SEG_9;
         default: seg_c = SEG_DASH;
      endcase
   end

endmodule

// File: rtl/bcd_display_scan.sv
// Time-multiplexed three-digit BCD display driver with guard cycles,
// leading-zero blanking and frame-synchronous double-buffered digit updates.
module bcd_display_scan
   import bcd_display_pkg::*;
#(
   parameter int unsigned DIV        = 50000,
   parameter bit          ACTIVE_LOW = 1'b1
) (
   input  logic               clock,
   input  logic               reset,
   bcd_display_scan_if.slave  bus
);

   localparam int unsigned     CNT_W    = $clog2(DIV);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIV - 1);
   localparam logic [SEG_W-1:0] SEG_IDLE = ACTIVE_LOW ? ~SEG_OFF : SEG_OFF;
   localparam logic [AN_W-1:0]  AN_IDLE  = ACTIVE_LOW ? {AN_W{1'b1}} : {AN_W{1'b0}};

   scan_state_e        state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   bcd_digits_t        disp_q, disp_d;
   bcd_digits_t        pnd_q, pnd_d;
   logic               pend_q, pend_d;
   logic [SEG_W-1:0]   seg_q, seg_d;
   logic [AN_W-1:0]    an_q, an_d;
   logic               frame_start_q, frame_start_d;

   logic               tick;
   logic               frame_wrap;
   bcd_digits_t        live;
   logic [DIGIT_W-1:0] cur_digit;
   logic [AN_W-1:0]    an_sel;
   logic               blank;
   logic [SEG_W-1:0]   dec_seg_c;
   logic               guard;
   logic [SEG_W-1:0]   seg_act;
   logic [AN_W-1:0]    an_act;

   assign tick       = (cnt_q == CNT_MAX);
   assign frame_wrap = tick && (state_q == S_HUND);
   assign live       = {bus.hundreds, bus.tens, bus.ones};

   // Scan state register
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= S_ONES;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state: advance one digit per prescaler period
   always_comb begin
      state_d = state_q;
      if (tick) begin
         case (state_q)
            S_ONES:  state_d = S_TENS;
            S_TENS:  state_d = S_HUND;
            S_HUND:  state_d = S_ONES;
            default: state_d = S_ONES;
         endcase
      end
   end

   // Digit, anode and blanking selection for the current slot
   always_comb begin
      cur_digit = disp_q.ones;
      an_sel    = 3'b001;
      blank     = 1'b0;
      case (state_q)
         S_TENS: begin
            cur_digit = disp_q.tens;
            an_sel    = 3'b010;
            blank     = bus.blank_lz && (disp_q.hundreds == '0) && (disp_q.tens == '0);
         end
         S_HUND: begin
            cur_digit = disp_q.hundreds;
            an_sel    = 3'b100;
            blank     = bus.blank_lz && (disp_q.hundreds == '0);
         end
         default: ;
      endcase
   end

   seg7_decode u_decode (
      .digit (cur_digit),
      .seg_c (dec_seg_c)
   );

   // Output decode; cnt == 0 is the anti-ghosting guard cycle
   always_comb begin
      guard         = (cnt_q == '0);
      seg_act       = (guard || blank) ? SEG_OFF : dec_seg_c;
      an_act        = guard ? {AN_W{1'b0}} : an_sel;
      seg_d         = ACTIVE_LOW ? ~seg_act : seg_act;
      an_d          = ACTIVE_LOW ? ~an_act : an_act;
      frame_start_d = guard && (state_q == S_ONES);
   end

   // Prescaler and double buffer; a load on the wrap tick bypasses pending
   always_comb begin
      cnt_d  = tick ? '0 : cnt_q + CNT_W'(1);
      disp_d = disp_q;
      pnd_d  = pnd_q;
      pend_d = pend_q;
      if (frame_wrap) begin
         if (bus.load) begin
            disp_d = live;
         end else if (pend_q) begin
            disp_d = pnd_q;
         end
         pend_d = 1'b0;
      end else if (bus.load) begin
         pnd_d  = live;
         pend_d = 1'b1;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         cnt_q         <= '0;
         disp_q        <= '0;
         pnd_q         <= '0;
         pend_q        <= 1'b0;
         seg_q         <= SEG_IDLE;
         an_q          <= AN_IDLE;
         frame_start_q <= 1'b0;
      end else begin
         cnt_q         <= cnt_d;
         disp_q        <= disp_d;
         pnd_q         <= pnd_d;
         pend_q        <= pend_d;
         seg_q         <= seg_d;
         an_q          <= an_d;
         frame_start_q <= frame_start_d;
      end
   end

   assign bus.seg         = seg_q;
   assign bus.an          = an_q;
   assign bus.frame_start = frame_start_q;

endmodule

// File: tb/tb_bcd_display_scan.sv
// Bench for bcd_display_scan: directed frame checks plus random loads against a slot-position model.
module tb_bcd_display_scan;

   localparam int DIV_T = 4;
   localparam int FRAME = 3 * DIV_T;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       load_r = 1'b0;
   logic [3:0] hund_r = 4'd0;
   logic [3:0] tens_r = 4'd0;
   logic [3:0] ones_r = 4'd0;
   logic       blz_r = 1'b0;

   int n_cmp = 0;
   int n_bad = 0;

   logic [6:0] seg_tbl [0:15] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                  7'h7F, 7'h6F, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40};

   bcd_display_scan_if if0 ();
   bcd_display_scan_if if1 ();

   assign if0.load = load_r;  assign if1.load = load_r;
   assign if0.hundreds = hund_r;  assign if1.hundreds = hund_r;
   assign if0.tens = tens_r;  assign if1.tens = tens_r;
   assign if0.ones = ones_r;  assign if1.ones = ones_r;
   assign if0.blank_lz = blz_r;  assign if1.blank_lz = blz_r;

   bcd_display_scan #(.DIV(DIV_T), .ACTIVE_LOW(1'b0)) dut0 (
      .clock (clock), .reset (reset), .bus (if0)
   );
   bcd_display_scan #(.DIV(DIV_T), .ACTIVE_LOW(1'b1)) dut1 (
      .clock (clock), .reset (reset), .bus (if1)
   );

   always #5 clock = ~clock;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at t=%0t", name, got, exp, $time);
      end
   endtask

   // Expected {frame_start, an, seg} (active-high) for slot position pos.
   function automatic logic [10:0] exp_out(input int pos, input logic [11:0] d, input logic blz);
      int c, s;
      logic [3:0] dig;
      logic [2:0] an_v;
      logic [6:0] seg_v;
      logic blank;
      c = pos % DIV_T;
      s = (pos / DIV_T) % 3;
      dig = (s == 0) ? d[3:0] : (s == 1) ? d[7:4] : d[11:8];
      blank = blz && (d[11:8] == 4'd0) && (s == 2 || (s == 1 && d[7:4] == 4'd0));
      an_v = (c == 0) ? 3'b000 : 3'(1 << s);
      seg_v = (c == 0 || blank) ? 7'h00 : seg_tbl[dig];
      return {(s == 0 && c == 0), an_v, seg_v};
   endfunction

   // Model: position within the frame, pending and shown digits.
   int          m_pos = 0;
   logic [11:0] m_disp = '0;
   logic [11:0] m_pnd = '0;
   logic        m_pend = 1'b0;
   logic [10:0] m_exp = '0;
   bit          m_valid = 1'b0;

   always @(posedge clock) begin
      if (reset) begin
         m_pos <= 0; m_disp <= '0; m_pnd <= '0; m_pend <= 1'b0;
         m_exp <= '0; m_valid <= 1'b1;
      end else if (m_valid) begin
         m_exp <= exp_out(m_pos, m_disp, blz_r);
         m_pos <= m_pos + 1;
         if (m_pos % FRAME == FRAME - 1) begin
            m_disp <= load_r ? {hund_r, tens_r, ones_r} : (m_pend ? m_pnd : m_disp);
            m_pend <= 1'b0;
         end else if (load_r) begin
            m_pnd  <= {hund_r, tens_r, ones_r};
            m_pend <= 1'b1;
         end
      end
   end

   always @(negedge clock) begin
      if (m_valid) begin
         chk("model_dut0", {if0.frame_start, if0.an, if0.seg}, 32'(m_exp));
         chk("model_dut1", {if1.frame_start, if1.an, if1.seg},
             32'({m_exp[10], ~m_exp[9:7], ~m_exp[6:0]}));
      end
   end

   task automatic wait_fs();
      int n;
      n = 0;
      do begin
         @(negedge clock);
         n++;
      end while (!if0.frame_start && n < 40);
      chk("frame_start_seen", 32'(if0.frame_start), 32'd1);
   endtask

   task automatic do_load(input logic [3:0] h, input logic [3:0] t, input logic [3:0] o);
      load_r = 1'b1; hund_r = h; tens_r = t; ones_r = o;
      @(negedge clock);
      load_r = 1'b0;
   endtask

   // Checks slot cycles k0..k1 of the current frame on dut0 against literal patterns.
   task automatic check_frame(input int k0, input int k1,
                              input logic [6:0] so, input logic [6:0] st, input logic [6:0] sh);
      int s, c;
      logic [6:0] sv;
      logic [9:0] ev;
      for (int k = k0; k <= k1; k++) begin
         if (k != k0) @(negedge clock);
         s = k / DIV_T;
         c = k % DIV_T;
         sv = (s == 0) ? so : (s == 1) ? st : sh;
         ev = (c == 0) ? 10'd0 : {3'(1 << s), sv};
         chk("frame_slot", {if0.an, if0.seg}, 32'(ev));
      end
   endtask

   initial begin
      repeat (3) @(negedge clock);
      chk("rst_dut0", {if0.frame_start, if0.an, if0.seg}, 32'h0);
      chk("rst_dut1", {if1.frame_start, if1.an, if1.seg}, 32'h3FF);
      reset = 1'b0;
      @(negedge clock);
      chk("first_fs", 32'(if0.frame_start), 32'd1);

      // Load 1/2/3: first frame stays 0/0/0
      do_load(4'd1, 4'd2, 4'd3);
      check_frame(1, 11, 7'h3F, 7'h3F, 7'h3F);
      wait_fs();
      check_frame(0, 11, 7'h4F, 7'h5B, 7'h06);

      // Leading-zero blanking
      wait_fs();
      blz_r = 1'b1;
      do_load(4'd0, 4'd0, 4'd7);
      check_frame(1, 11, 7'h4F, 7'h5B, 7'h06);
      wait_fs();
      check_frame(0, 11, 7'h07, 7'h00, 7'h00);
      wait_fs();
      do_load(4'd0, 4'd0, 4'd0);
      check_frame(1, 11, 7'h07, 7'h00, 7'h00);
      wait_fs();
      check_frame(0, 11, 7'h3F, 7'h00, 7'h00);

      // Last load in a frame wins
      wait_fs();
      blz_r = 1'b0;
      do_load(4'd2, 4'd5, 4'd5);
      @(negedge clock);
      do_load(4'd1, 4'd0, 4'd0);
      check_frame(3, 11, 7'h3F, 7'h3F, 7'h3F);
      wait_fs();
      check_frame(0, 11, 7'h3F, 7'h3F, 7'h06);

      // Load on the wrap tick overrides a pending value
      wait_fs();
      do_load(4'd9, 4'd9, 4'd9);
      check_frame(1, 10, 7'h3F, 7'h3F, 7'h06);
      do_load(4'd4, 4'd5, 4'd6);
      check_frame(11, 11, 7'h3F, 7'h3F, 7'h06);
      wait_fs();
      check_frame(0, 11, 7'h7D, 7'h6D, 7'h66);
      wait_fs();
      check_frame(0, 11, 7'h7D, 7'h6D, 7'h66);

      // Dash for non-decimal code, inverted polarity
      wait_fs();
      do_load(4'd3, 4'hC, 4'd8);
      check_frame(1, 11, 7'h7D, 7'h6D, 7'h66);
      wait_fs();
      check_frame(0, 11, 7'h7F, 7'h40, 7'h4F);
      wait_fs();
      @(negedge clock);
      chk("al_ones", {if1.an, if1.seg}, 32'({3'b110, 7'h00}));

      // Reset during tens slot with a load pending
      wait_fs();
      do_load(4'd7, 4'd7, 4'd7);
      check_frame(1, 5, 7'h7F, 7'h40, 7'h4F);
      reset = 1'b1;
      @(negedge clock);
      chk("midrst_dut0", {if0.frame_start, if0.an, if0.seg}, 32'h0);
      reset = 1'b0;
      @(negedge clock);
      chk("midrst_fs", 32'(if0.frame_start), 32'd1);
      check_frame(0, 11, 7'h3F, 7'h3F, 7'h3F);
      wait_fs();
      check_frame(0, 11, 7'h3F, 7'h3F, 7'h3F);

      // Random loads, blanking toggles and occasional resets
      for (int i = 0; i < 2000; i++) begin
         @(negedge clock);
         load_r = ($urandom % 8) == 0;
         hund_r = 4'($urandom % 16);
         tens_r = 4'($urandom % 16);
         ones_r = 4'($urandom % 16);
         if (($urandom % 50) == 0) blz_r = ~blz_r;
         reset = ($urandom % 400) == 0;
      end
      @(negedge clock);
      reset = 1'b0;
      load_r = 1'b0;
      repeat (2 * FRAME) @(negedge clock);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
